// File: rtl/hazard_ctrl_multi.sv
// Multi-cycle load-use / branch-flush / freeze hazard controller for the ID stage.
// Optional performance counters are enabled with `define HAZ_PERF_CNT_EN.
module hazard_ctrl_multi #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LOAD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ifid_rs1,
   input  logic [REG_AW-1:0] ifid_rs2,
   input  logic              ifid_rs1_used,
   input  logic              ifid_rs2_used,
   input  logic [REG_AW-1:0] idex_rd,
   input  logic              idex_mem_read,
   input  logic              branch_taken,
   input  logic              ext_stall,
   output logic              pc_write_en,
   output logic              ifid_write_en,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic              load_use_stall
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_cycles
`endif
);

   localparam int unsigned NSTG = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

   logic w_trk_rs1;
   logic w_trk_rs2;
   logic w_src1_hit;
   logic w_src2_hit;
   logic w_hazard;

   generate
      if (LOAD_LAT > 1) begin : g_trk
         logic [NSTG-1:0]   r_vld;
         logic [REG_AW-1:0] r_rd [NSTG];

         // In-flight load destinations, shifted once per unfrozen cycle
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vld <= '0;
               for (int i = 0; i < NSTG; i++) r_rd[i] <= '0;
            end else if (!ext_stall) begin
               r_vld[0] <= idex_mem_read && (idex_rd != '0);
               r_rd[0]  <= idex_rd;
               for (int i = 1; i < NSTG; i++) begin
                  r_vld[i] <= r_vld[i-1];
                  r_rd[i]  <= r_rd[i-1];
               end
            end
         end

         always_comb begin
            w_trk_rs1 = 1'b0;
            w_trk_rs2 = 1'b0;
            for (int i = 0; i < NSTG; i++) begin
               if (r_vld[i] && (r_rd[i] == ifid_rs1)) w_trk_rs1 = 1'b1;
               if (r_vld[i] && (r_rd[i] == ifid_rs2)) w_trk_rs2 = 1'b1;
            end
         end
      end else begin : g_no_trk
         assign w_trk_rs1 = 1'b0;
         assign w_trk_rs2 = 1'b0;
      end
   endgenerate

   assign w_src1_hit = ifid_rs1_used && (ifid_rs1 != '0) &&
                       ((idex_mem_read && (idex_rd == ifid_rs1)) || w_trk_rs1);
   assign w_src2_hit = ifid_rs2_used && (ifid_rs2 != '0) &&
                       ((idex_mem_read && (idex_rd == ifid_rs2)) || w_trk_rs2);
   assign w_hazard   = w_src1_hit || w_src2_hit;

   // Priority: reset, freeze, branch flush, load-use stall, normal flow
   always_comb begin
      pc_write_en    = 1'b1;
      ifid_write_en  = 1'b1;
      idex_bubble    = 1'b0;
      ifid_flush     = 1'b0;
      load_use_stall = 1'b0;
      if (rst || ext_stall) begin
         pc_write_en    = 1'b0;
         ifid_write_en  = 1'b0;
      end else if (branch_taken) begin
         idex_bubble    = 1'b1;
         ifid_flush     = 1'b1;
      end else if (w_hazard) begin
         pc_write_en    = 1'b0;
         ifid_write_en  = 1'b0;
         idex_bubble    = 1'b1;
         load_use_stall = 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   // Saturating event counters, frozen along with the pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else if (!ext_stall) begin
         if (load_use_stall && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'(1);
         if (ifid_flush && (flush_cycles != 32'hFFFF_FFFF))
            flush_cycles <= flush_cycles + 32'(1);
      end
   end
`endif

endmodule
